// File: rtl/motion_bbox_pkg.sv
// Shared definitions for the motion_bbox block: datapath widths, the empty
// bounding-box sentinel, the output FSM state encoding and the result record.
// Optional centroid build: MOTION_BBOX_CENTROID_EN.
package motion_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 19;
  localparam int SUM_W   = 28;

  // Accumulator min registers start here so the first foreground pixel wins.
  localparam logic [COORD_W-1:0] COORD_EMPTY = 11'h7FF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_CALC  = 2'd1,
    ST_FULL  = 2'd2
  } bbox_state_t;

  typedef struct packed {
    logic               present;
    logic [COORD_W-1:0] x_min;
    logic [COORD_W-1:0] x_max;
    logic [COORD_W-1:0] y_min;
    logic [COORD_W-1:0] y_max;
    logic [CNT_W-1:0]   pix_cnt;
  } bbox_res_t;

endpackage

// File: rtl/motion_bbox_if.sv
// Result channel from motion_bbox toward the host/UART reporting stage.
// Handshake: the master raises bb_valid when a frame result is held and keeps
// the payload stable until a rising clock edge sees bb_valid & bb_ready (the
// transfer); the only exception is an overrun, where a newer frame result
// replaces the held one and bb_valid stays high.
// Optional centroid fields cx/cy exist only with MOTION_BBOX_CENTROID_EN.
interface motion_bbox_if;
  import motion_pkg::*;

  logic               bb_valid;
  logic               bb_ready;
  logic               present;
  logic [COORD_W-1:0] x_min;
  logic [COORD_W-1:0] x_max;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;
  logic [CNT_W-1:0]   pix_cnt;
  logic               overrun;
`ifdef MOTION_BBOX_CENTROID_EN
  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;
`endif

  modport master (
    output bb_valid, present, x_min, x_max, y_min, y_max, pix_cnt, overrun,
`ifdef MOTION_BBOX_CENTROID_EN
    output cx, cy,
`endif
    input  bb_ready
  );

  modport slave (
    input  bb_valid, present, x_min, x_max, y_min, y_max, pix_cnt, overrun,
`ifdef MOTION_BBOX_CENTROID_EN
    input  cx, cy,
`endif
    output bb_ready
  );

endinterface

// File: rtl/motion_bbox_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle (N_W cycles after
// start). start loads the operands; done pulses for one cycle together with a
// valid quotient. The caller guarantees a non-zero divisor.
module seq_divider #(
  parameter int N_W = 28,
  parameter int D_W = 19
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           done,
  output logic [N_W-1:0] quotient
);

  localparam int CW = $clog2(N_W);

  logic [D_W-1:0] rem;
  logic [N_W-1:0] quo;
  logic [D_W-1:0] dvs;
  logic [CW-1:0]  bit_cnt;
  logic           busy;
  logic [D_W:0]   rem_sh;
  logic           ge;

  // Partial remainder shifted left by one with the next dividend bit.
  assign rem_sh = {rem, quo[N_W-1]};
  assign ge     = rem_sh >= {1'b0, dvs};

  // Load on start, then one restoring step per cycle until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      rem     <= '0;
      quo     <= dividend;
      dvs     <= divisor;
      bit_cnt <= CW'(N_W - 1);
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (busy) begin
      rem <= ge ? D_W'(rem_sh - {1'b0, dvs}) : rem_sh[D_W-1:0];
      quo <= {quo[N_W-2:0], ge};
      if (bit_cnt == '0) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt - CW'(1);
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/motion_bbox.sv
// Per-frame bounding box and pixel count of eroded foreground pixels. The
// eroder output trails the raster counters by PIX_H_LAG columns and PIX_V_LAG
// lines; this block undoes that lag so results are in image coordinates.
// A finished frame is held in a result register behind a valid/ready channel.
// Optional centroid (cx, cy via two sequential dividers): MOTION_BBOX_CENTROID_EN.
module motion_bbox
  import motion_pkg::*;
#(
  parameter int H_IMG_RES = 640,
  parameter int V_IMG_RES = 480,
  parameter int PIX_H_LAG = 2,
  parameter int PIX_V_LAG = 3,
  parameter int MIN_PIX   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  input  logic               in_pix,
  motion_bbox_if.master      bb,
  output bbox_state_t        fsm_state
);

  localparam int LW = COORD_W + 2;
  localparam logic signed [LW-1:0] H_RES_S = LW'(H_IMG_RES);
  localparam logic signed [LW-1:0] V_RES_S = LW'(V_IMG_RES);
  localparam logic signed [LW-1:0] H_LAG_S = LW'(PIX_H_LAG);
  localparam logic signed [LW-1:0] V_LAG_S = LW'(PIX_V_LAG);
  localparam logic signed [LW-1:0] ONE_S   = LW'(1);

  logic signed [LW-1:0] x_s, y_s;
  logic [COORD_W-1:0]   x, y;
  logic                 col_wrap, in_img, hit, frame_end;

  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [COORD_W-1:0] xmin, xmax, ymin, ymax;
  logic [COORD_W-1:0] xmin_nxt, xmax_nxt, ymin_nxt, ymax_nxt;
  logic               present_nxt;
  bbox_res_t          res_nxt, result;

  bbox_state_t state;
  logic        valid, overrun;

  // Map the lagged raster position back to the image position of in_pix.
  always_comb begin
    x_s      = $signed({2'b00, hpos}) - H_LAG_S;
    col_wrap = x_s < 0;
    if (col_wrap) x_s = x_s + H_RES_S;
    y_s = $signed({2'b00, vpos}) - V_LAG_S - (col_wrap ? ONE_S : '0);
    if (y_s < 0) y_s = y_s + V_RES_S;
    in_img    = (x_s >= 0) && (x_s < H_RES_S) && (y_s >= 0) && (y_s < V_RES_S);
    x         = x_s[COORD_W-1:0];
    y         = y_s[COORD_W-1:0];
    hit       = in_pix && in_img;
    frame_end = (x_s == H_RES_S - ONE_S) && (y_s == V_RES_S - ONE_S);
  end

  // Accumulator values including the current pixel; also the frame result.
  always_comb begin
    cnt_nxt  = cnt;
    xmin_nxt = xmin;
    xmax_nxt = xmax;
    ymin_nxt = ymin;
    ymax_nxt = ymax;
    if (hit) begin
      cnt_nxt = cnt + CNT_W'(1);
      if (x < xmin) xmin_nxt = x;
      if (x > xmax) xmax_nxt = x;
      if (y < ymin) ymin_nxt = y;
      if (y > ymax) ymax_nxt = y;
    end
    // A zero count never reports, whatever MIN_PIX is.
    present_nxt     = (cnt_nxt >= CNT_W'(MIN_PIX)) && (cnt_nxt != '0);
    res_nxt.present = present_nxt;
    res_nxt.x_min   = present_nxt ? xmin_nxt : '0;
    res_nxt.x_max   = present_nxt ? xmax_nxt : '0;
    res_nxt.y_min   = present_nxt ? ymin_nxt : '0;
    res_nxt.y_max   = present_nxt ? ymax_nxt : '0;
    res_nxt.pix_cnt = cnt_nxt;
  end

  // Frame accumulators; the frame-end pixel is folded into res_nxt, so the
  // registers go straight back to the empty state on that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      xmin <= COORD_EMPTY;
      xmax <= '0;
      ymin <= COORD_EMPTY;
      ymax <= '0;
    end else if (frame_end) begin
      cnt  <= '0;
      xmin <= COORD_EMPTY;
      xmax <= '0;
      ymin <= COORD_EMPTY;
      ymax <= '0;
    end else begin
      cnt  <= cnt_nxt;
      xmin <= xmin_nxt;
      xmax <= xmax_nxt;
      ymin <= ymin_nxt;
      ymax <= ymax_nxt;
    end
  end

`ifdef MOTION_BBOX_CENTROID_EN
  logic [SUM_W-1:0]   sum_x, sum_y, sum_x_nxt, sum_y_nxt;
  logic [SUM_W-1:0]   quo_x, quo_y;
  logic [CNT_W-1:0]   div_dvs;
  logic               div_start, done_x, done_y, div_done;
  logic               handshake;
  bbox_res_t          pend;
  logic [COORD_W-1:0] cx, cy;

  assign sum_x_nxt = sum_x + (hit ? SUM_W'(x) : '0);
  assign sum_y_nxt = sum_y + (hit ? SUM_W'(y) : '0);
  // A non-reporting frame divides by 1 so latency stays fixed and never /0.
  assign div_dvs   = present_nxt ? cnt_nxt : CNT_W'(1);
  assign div_start = frame_end && (state != ST_CALC);
  assign div_done  = done_x & done_y;
  assign handshake = valid & bb.bb_ready;

  // Coordinate sums for the centroid, cleared with the other accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x <= '0;
      sum_y <= '0;
    end else if (frame_end) begin
      sum_x <= '0;
      sum_y <= '0;
    end else begin
      sum_x <= sum_x_nxt;
      sum_y <= sum_y_nxt;
    end
  end

  seq_divider #(.N_W(SUM_W), .D_W(CNT_W)) u_div_x (
    .clk(clk), .rst_n(rst_n), .start(div_start), .dividend(sum_x_nxt),
    .divisor(div_dvs), .done(done_x), .quotient(quo_x)
  );

  seq_divider #(.N_W(SUM_W), .D_W(CNT_W)) u_div_y (
    .clk(clk), .rst_n(rst_n), .start(div_start), .dividend(sum_y_nxt),
    .divisor(div_dvs), .done(done_y), .quotient(quo_y)
  );

  assign bb.cx = cx;
  assign bb.cy = cy;
`endif

  // Output FSM: result register, valid/ready handshake and overrun tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      valid   <= 1'b0;
      overrun <= 1'b0;
      result  <= '0;
`ifdef MOTION_BBOX_CENTROID_EN
      pend    <= '0;
      cx      <= '0;
      cy      <= '0;
`endif
    end else begin
      case (state)
        ST_EMPTY: begin
          if (frame_end) begin
`ifdef MOTION_BBOX_CENTROID_EN
            pend  <= res_nxt;
            state <= ST_CALC;
`else
            result <= res_nxt;
            valid  <= 1'b1;
            state  <= ST_FULL;
`endif
          end
        end
`ifdef MOTION_BBOX_CENTROID_EN
        // The previous result may still be held here; the new one replaces it
        // only when the quotients are ready.
        ST_CALC: begin
          if (div_done) begin
            result  <= pend;
            cx      <= pend.present ? COORD_W'(quo_x) : '0;
            cy      <= pend.present ? COORD_W'(quo_y) : '0;
            valid   <= 1'b1;
            overrun <= valid & ~bb.bb_ready;
            state   <= ST_FULL;
          end else if (handshake) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
          end
        end
`endif
        ST_FULL: begin
          if (frame_end) begin
`ifdef MOTION_BBOX_CENTROID_EN
            pend  <= res_nxt;
            state <= ST_CALC;
            if (bb.bb_ready) begin
              valid   <= 1'b0;
              overrun <= 1'b0;
            end
`else
            // Overwrite; a same-cycle handshake took the old result cleanly.
            result  <= res_nxt;
            overrun <= ~bb.bb_ready;
`endif
          end else if (bb.bb_ready) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            state   <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bb.bb_valid = valid;
  assign bb.overrun  = overrun;
  assign bb.present  = result.present;
  assign bb.x_min    = result.x_min;
  assign bb.x_max    = result.x_max;
  assign bb.y_min    = result.y_min;
  assign bb.y_max    = result.y_max;
  assign bb.pix_cnt  = result.pix_cnt;
  assign fsm_state   = state;

endmodule

// File: tb/tb_motion_bbox.sv
// Directed bench for motion_bbox on a 32x32 image (lags 2/3). Two instances
// share one raster: u_dut0 with MIN_PIX=16 and u_dut1 with MIN_PIX=1.
module tb_motion_bbox;
  import motion_pkg::*;

  localparam int H_RES = 32;
  localparam int V_RES = 32;
  localparam int N_PIX = H_RES * V_RES;
  // Raster index at which image pixel (0,0) is presented: 3 lines + 2 columns.
  localparam int OFFS  = 3 * H_RES + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [COORD_W-1:0] hpos, vpos;
  logic               in_pix;
  logic               bb_ready;
  bbox_state_t        st0, st1;

  motion_bbox_if bif0 ();
  motion_bbox_if bif1 ();
  assign bif0.bb_ready = bb_ready;
  assign bif1.bb_ready = bb_ready;

  motion_bbox #(.H_IMG_RES(H_RES), .V_IMG_RES(V_RES), .PIX_H_LAG(2),
                .PIX_V_LAG(3), .MIN_PIX(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .in_pix(in_pix),
    .bb(bif0), .fsm_state(st0)
  );

  motion_bbox #(.H_IMG_RES(H_RES), .V_IMG_RES(V_RES), .PIX_H_LAG(2),
                .PIX_V_LAG(3), .MIN_PIX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .in_pix(in_pix),
    .bb(bif1), .fsm_state(st1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk0(input string tag, input int pres, input int xmn,
                      input int xmx, input int ymn, input int ymx, input int cnt);
    check_eq({tag, "_d0_valid"}, 32'(bif0.bb_valid), 32'd1);
    check_eq({tag, "_d0_present"}, 32'(bif0.present), 32'(pres));
    check_eq({tag, "_d0_xmin"}, 32'(bif0.x_min), 32'(xmn));
    check_eq({tag, "_d0_xmax"}, 32'(bif0.x_max), 32'(xmx));
    check_eq({tag, "_d0_ymin"}, 32'(bif0.y_min), 32'(ymn));
    check_eq({tag, "_d0_ymax"}, 32'(bif0.y_max), 32'(ymx));
    check_eq({tag, "_d0_cnt"}, 32'(bif0.pix_cnt), 32'(cnt));
  endtask

  task automatic chk1(input string tag, input int pres, input int xmn,
                      input int xmx, input int ymn, input int ymx, input int cnt);
    check_eq({tag, "_d1_valid"}, 32'(bif1.bb_valid), 32'd1);
    check_eq({tag, "_d1_present"}, 32'(bif1.present), 32'(pres));
    check_eq({tag, "_d1_xmin"}, 32'(bif1.x_min), 32'(xmn));
    check_eq({tag, "_d1_xmax"}, 32'(bif1.x_max), 32'(xmx));
    check_eq({tag, "_d1_ymin"}, 32'(bif1.y_min), 32'(ymn));
    check_eq({tag, "_d1_ymax"}, 32'(bif1.y_max), 32'(ymx));
    check_eq({tag, "_d1_cnt"}, 32'(bif1.pix_cnt), 32'(cnt));
  endtask

  // ---------------- image and raster driver ----------------
  logic fg [N_PIX];
  int   pos;

  task automatic clear_fg();
    for (int i = 0; i < N_PIX; i++) fg[i] = 1'b0;
  endtask

  task automatic set_rect(input int x0, input int x1, input int y0, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) fg[yy * H_RES + xx] = 1'b1;
  endtask

  // One raster cycle: present the eroder bit for the image pixel that the lag
  // places at this raster position.
  task automatic tick(input logic rdy);
    int idx;
    hpos     = 11'(pos % H_RES);
    vpos     = 11'(pos / H_RES);
    idx      = (pos - OFFS + N_PIX) % N_PIX;
    in_pix   = fg[idx];
    bb_ready = rdy;
    @(posedge clk);
    #1;
    pos = (pos + 1) % N_PIX;
  endtask

  // All pixels of an image frame except the frame-end pixel.
  task automatic frame_body(input logic accept, input string tag);
    tick(accept);
    if (accept) check_eq({tag, "_hs_drop"}, 32'(bif0.bb_valid), 32'd0);
    for (int i = 1; i < N_PIX - 1; i++) tick(1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n    = 1'b1;
    hpos     = '0;
    vpos     = '0;
    in_pix   = 1'b0;
    bb_ready = 1'b0;
    pos      = 0;
    clear_fg();
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(bif0.bb_valid), 32'd0);
    check_eq("rst_overrun", 32'(bif0.overrun), 32'd0);
    check_eq("rst_cnt", 32'(bif0.pix_cnt), 32'd0);
    check_eq("rst_state", 32'(st0), 32'(ST_EMPTY));
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Tail of a partial frame after reset: first result at the next frame end.
    for (int i = 0; i < OFFS - 1; i++) tick(1'b0);
    check_eq("pre_valid_low", 32'(bif0.bb_valid), 32'd0);
    tick(1'b0);
    chk0("prelude", 0, 0, 0, 0, 0, 0);
    check_eq("prelude_state", 32'(st0), 32'(ST_FULL));

    // Single pixel, reported only by the MIN_PIX=1 instance.
    clear_fg();
    set_rect(12, 12, 7, 7);
    frame_body(1'b1, "single");
    check_eq("single_valid_low", 32'(bif1.bb_valid), 32'd0);
    tick(1'b0);
    chk1("single", 1, 12, 12, 7, 7, 1);
    chk0("single", 0, 0, 0, 0, 0, 1);

    // 10x20 rectangle, 200 pixels.
    clear_fg();
    set_rect(10, 19, 5, 24);
    frame_body(1'b1, "rect");
    tick(1'b0);
    chk0("rect", 1, 10, 19, 5, 24, 200);

    // 15 pixels: one short of MIN_PIX for u_dut0.
    clear_fg();
    set_rect(0, 14, 3, 3);
    frame_body(1'b1, "min15");
    tick(1'b0);
    chk0("min15", 0, 0, 0, 0, 0, 15);
    chk1("min15", 1, 0, 14, 3, 3, 15);

    // Opposite corners: (0,0) at hpos=2, (31,31) through the column wrap.
    clear_fg();
    fg[0]         = 1'b1;
    fg[N_PIX - 1] = 1'b1;
    frame_body(1'b1, "corner");
    tick(1'b0);
    chk1("corner", 1, 0, 31, 0, 31, 2);

    // Overrun: frame A left unconsumed, frame B overwrites it.
    clear_fg();
    set_rect(0, 19, 0, 0);
    frame_body(1'b1, "frmA");
    tick(1'b0);
    chk0("frmA", 1, 0, 19, 0, 0, 20);
    clear_fg();
    set_rect(2, 5, 8, 11);
    frame_body(1'b0, "frmB");
    check_eq("frmB_hold_valid", 32'(bif0.bb_valid), 32'd1);
    check_eq("frmB_hold_xmax", 32'(bif0.x_max), 32'd19);
    check_eq("frmB_hold_ovr", 32'(bif0.overrun), 32'd0);
    tick(1'b0);
    chk0("frmB", 1, 2, 5, 8, 11, 16);
    check_eq("frmB_overrun", 32'(bif0.overrun), 32'd1);

    // Accept B; overrun clears with the transfer.
    clear_fg();
    set_rect(3, 3, 4, 4);
    frame_body(1'b1, "frmC");
    check_eq("frmC_ovr_clr", 32'(bif0.overrun), 32'd0);
    tick(1'b0);
    chk0("frmC", 0, 0, 0, 0, 0, 1);

    // Frame end coinciding with a handshake: new result, no overrun.
    clear_fg();
    set_rect(20, 23, 28, 31);
    frame_body(1'b0, "frmD");
    tick(1'b1);
    chk0("frmD", 1, 20, 23, 28, 31, 16);
    check_eq("frmD_overrun", 32'(bif0.overrun), 32'd0);

    // Reset mid-frame while a result is held.
    clear_fg();
    set_rect(0, 31, 2, 2);
    set_rect(0, 15, 20, 20);
    for (int i = 0; i < N_PIX - 1; i++) begin
      if (i == 352) begin
        rst_n = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(bif0.bb_valid), 32'd0);
        check_eq("mrst_present", 32'(bif0.present), 32'd0);
        check_eq("mrst_xmin", 32'(bif0.x_min), 32'd0);
        check_eq("mrst_cnt", 32'(bif0.pix_cnt), 32'd0);
        check_eq("mrst_state", 32'(st0), 32'(ST_EMPTY));
      end
      if (i == 356) rst_n = 1'b1;
      tick(1'b0);
    end
    tick(1'b0);
    chk0("postrst", 1, 0, 15, 20, 20, 16);
    check_eq("postrst_overrun", 32'(bif0.overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motion_bbox.md
# motion_bbox

Downstream consumer of the binary eroder output in the motion-segmentation pipeline. Per frame, accumulates the bounding box and pixel count of surviving foreground pixels. At frame end, latches the result into an output register presented with a valid/ready handshake toward the host/UART reporting stage. Compensates the eroder's fixed line/column lag, so reported coordinates are in image space.

## Interface
- H_IMG_RES, 640, active pixels per line
- V_IMG_RES, 480, active lines per frame
- PIX_H_LAG, 2, columns by which `in_pix` trails `hpos`
- PIX_V_LAG, 3, lines by which `in_pix` trails `vpos`
- MIN_PIX, 16, minimum foreground count for a frame to report `present=1`

- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hpos  in  11  raster column counter, same timing as the eroder's
- vpos  in  11  raster line counter, same timing as the eroder's
- in_pix  in  1  eroded foreground bit (eroder output)
- bb_valid  out  1  result register holds an unconsumed frame result
- bb_ready  in  1  consumer accepts the result when high with `bb_valid`
- present  out  1  frame count ≥ MIN_PIX
- x_min, x_max  out  11  bounding-box columns
- y_min, y_max  out  11  bounding-box lines
- pix_cnt  out  19  foreground pixel count
- overrun  out  1  sticky: a result was overwritten before it was accepted

## Operation
- Lagged coordinates:
  - x = hpos − PIX_H_LAG, wrapping by +H_IMG_RES.
  - On a wrap, the line is taken one less.
  - y = vpos − PIX_V_LAG (minus 1 on a column wrap), wrapping by +V_IMG_RES.
- Only pixels with x < H_IMG_RES and y < V_IMG_RES are considered.
- When `in_pix=1`:
  - `cnt` increments.
  - `xmin`/`xmax`/`ymin`/`ymax` update with min/max compares against x/y.
- Frame end is the cycle where (x,y) = (H_IMG_RES−1, V_IMG_RES−1). In that cycle:
  - That pixel's contribution is included in the latched result.
  - The accumulators are reloaded to the empty state in the same cycle.
- Empty state of the accumulators: `cnt=0`, `xmin=ymin=11'h7FF`, `xmax=ymax=0`.
- Output FSM states: EMPTY, CALC, FULL.
  - EMPTY → (frame end) → FULL.
  - With the centroid option: EMPTY → CALC → FULL.
  - FULL → (`bb_ready`) → EMPTY.
- Latching a result:
  - If cnt < MIN_PIX: `present=0` and all coordinate outputs are 0. `pix_cnt` still holds the true count.
  - Otherwise: `present=1` and the outputs take the accumulated values.
- Frame end while FULL:
  - The result register is overwritten with the new result.
  - `overrun` is set.
  - `bb_valid` stays high.
- `overrun` clears on the cycle a handshake completes.
- Frame end while CALC cannot occur for any legal H_IMG_RES·V_IMG_RES. No handling is required beyond ignoring the event.
- Reset:
  - All outputs are 0 and the FSM is in EMPTY.
  - Accumulators are in the empty state.
  - Any partial frame that is interrupted is discarded.
  - The first result after reset is produced at the next frame end.

## Timing
- Accumulator update: registered, 1 cycle after the pixel.
- Without the centroid option, `bb_valid` rises 1 cycle after the frame-end pixel.
- Handshake:
  - A transfer occurs on a rising edge with `bb_valid & bb_ready`.
  - `bb_valid` drops the next cycle.
  - Outputs stay stable while `bb_valid & ~bb_ready`, except during an overrun overwrite.
- Simultaneous frame end and handshake: the new result is loaded, `bb_valid` stays 1, and `overrun` stays 0.
- All outputs are registered.

## Configuration
- MOTION_BBOX_CENTROID_EN defined:
  - Accumulates sum_x and sum_y (28 bits each) over foreground pixels.
  - At frame end, enters CALC.
  - Computes cx = sum_x / cnt and cy = sum_y / cnt using two parallel restoring dividers, 28 cycles each.
  - Adds outputs `cx` and `cy` (11 bits each), both 0 when `present=0`.
  - `bb_valid` rises 30 cycles after the frame-end pixel.
  - A divide by 0 is never started; `cnt=0` implies `present=0`.
- Undefined: no sums, no CALC state, no `cx`/`cy` ports.

## Structure
- Shared package `motion_pkg`:
  - Coordinate width (11) and count width (19).
  - Sum width (28) and the empty-state sentinel constant.
  - Output FSM state enum.
- Sub-module `seq_divider`: unsigned restoring divider with parameterised widths, `start`/`done` handshake, instantiated twice under the macro.
- Lag/wrap coordinate mapping stays inline.

## Test plan
- Single 1-pixel blob at image (100,50) with MIN_PIX=1:
  - Result: bbox 100/100/50/50, `pix_cnt=1`, `present=1`.
  - `bb_valid` 1 cycle after frame end (30 with centroid, cx=100, cy=50).
- Rectangle x 10..19, y 5..24 (200 px): bbox 10/19/5/24, `pix_cnt=200`, `present=1`.
- Frame with 15 foreground pixels and MIN_PIX=16: `present=0`, coordinates 0, `pix_cnt=15`.
- Pixel at image (0,0) and (639,479) fed with lag applied (presented at hpos=2 of the frame's first line and via column wrap): bbox 0/639/0/479 with no wrap errors.
- Hold `bb_ready=0` across two frame ends:
  - Second result replaces the first and `overrun=1`.
  - Raising `bb_ready` transfers the second result and clears `overrun`.
- Assert `rst_n=0` mid-frame with `bb_valid=1`:
  - Outputs go to 0 immediately.
  - Next frame end reports only post-reset pixels.
